// File: rtl/if_id_skid_buffer.sv
// IF/ID pipeline register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid that makes the upstream ready a registered signal.
module if_id_skid_buffer #(
    parameter int INSTR_W = 16,
    parameter int PC_W    = 32,
    parameter bit SKID    = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [INSTR_W-1:0] in_instruction_i,
    input  logic [PC_W-1:0]    in_pc_i,
    input  logic [PC_W-1:0]    in_next_pc_i,
    input  logic               in_bubble_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [INSTR_W-1:0] out_instruction_o,
    output logic [PC_W-1:0]    out_pc_o,
    output logic [PC_W-1:0]    out_next_pc_o,
    output logic               out_bubble_o,
    output logic [1:0]         occupancy_o
);

    localparam int PW = INSTR_W + 2 * PC_W + 1;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    logic [1:0]    occ_q, occ_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] skid_q, skid_d;
    logic [PW-1:0] in_word;
    logic          accept, pop;

    assign in_word = {in_instruction_i, in_pc_i, in_next_pc_i, in_bubble_i};
    assign {out_instruction_o, out_pc_o, out_next_pc_o, out_bubble_o} = head_q;
    assign out_valid_o = (occ_q != OCC_EMPTY);
    assign occupancy_o = occ_q;

    assign accept = in_valid_i & in_ready_o;
    assign pop    = out_valid_o & out_ready_i;

    // The head is kept zeroed whenever it is empty, so the outputs need no masking.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        skid_d = skid_q;
        if (flush_i) begin
            occ_d  = OCC_EMPTY;
            head_d = '0;
            skid_d = '0;
        end else begin
            case (occ_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        occ_d  = OCC_ONE;
                        head_d = in_word;
                    end
                end
                OCC_ONE: begin
                    if (accept && pop) begin
                        head_d = in_word;
                    end else if (accept && SKID) begin
                        occ_d  = OCC_TWO;
                        skid_d = in_word;
                    end else if (pop) begin
                        occ_d  = OCC_EMPTY;
                        head_d = '0;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        occ_d  = OCC_ONE;
                        head_d = skid_q;
                        skid_d = '0;
                    end
                end
                default: begin
                    occ_d  = OCC_EMPTY;
                    head_d = '0;
                    skid_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_q  <= OCC_EMPTY;
            head_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic in_ready_q;

            // Ready is precomputed from the next occupancy so fetch never sees a comb path.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    skid_q     <= '0;
                    in_ready_q <= 1'b1;
                end else begin
                    skid_q     <= skid_d;
                    in_ready_q <= (occ_d != OCC_TWO);
                end
            end

            assign in_ready_o = in_ready_q;
        end else begin : g_noskid
            assign skid_q     = '0;
            assign in_ready_o = ~out_valid_o | out_ready_i;
        end
    endgenerate

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench: vector table on the skid variant, hand sequence on the single-entry variant.
module tb_if_id_skid_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Skid variant signals.
    logic        rst1, flush1, inValid1, inReady1, inBubble1, outValid1, outReady1, outBubble1;
    logic [15:0] inInstr1, outInstr1;
    logic [31:0] inPc1, inNextPc1, outPc1, outNextPc1;
    logic [1:0]  occ1;

    // Single-entry variant signals.
    logic        rst0, flush0, inValid0, inReady0, inBubble0, outValid0, outReady0, outBubble0;
    logic [15:0] inInstr0, outInstr0;
    logic [31:0] inPc0, inNextPc0, outPc0, outNextPc0;
    logic [1:0]  occ0;

    if_id_skid_buffer #(.INSTR_W(16), .PC_W(32), .SKID(1'b1)) dutSkid (
        .clk_i(clk), .rst_i(rst1), .flush_i(flush1),
        .in_valid_i(inValid1), .in_ready_o(inReady1),
        .in_instruction_i(inInstr1), .in_pc_i(inPc1), .in_next_pc_i(inNextPc1), .in_bubble_i(inBubble1),
        .out_valid_o(outValid1), .out_ready_i(outReady1),
        .out_instruction_o(outInstr1), .out_pc_o(outPc1), .out_next_pc_o(outNextPc1), .out_bubble_o(outBubble1),
        .occupancy_o(occ1)
    );

    if_id_skid_buffer #(.INSTR_W(16), .PC_W(32), .SKID(1'b0)) dutNoSkid (
        .clk_i(clk), .rst_i(rst0), .flush_i(flush0),
        .in_valid_i(inValid0), .in_ready_o(inReady0),
        .in_instruction_i(inInstr0), .in_pc_i(inPc0), .in_next_pc_i(inNextPc0), .in_bubble_i(inBubble0),
        .out_valid_o(outValid0), .out_ready_i(outReady0),
        .out_instruction_o(outInstr0), .out_pc_o(outPc0), .out_next_pc_o(outNextPc0), .out_bubble_o(outBubble0),
        .occupancy_o(occ0)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        inValid;
        logic [15:0] instr;
        logic [31:0] pc;
        logic        bubble;
        logic        outReady;
        logic        expValid;
        logic [15:0] expInstr;
        logic [31:0] expPc;
        logic        expBubble;
        logic [1:0]  expOcc;
        logic        expInReady;
    } vector_t;

    vector_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic r, input logic f, input logic iv, input logic [15:0] ins,
                          input logic [31:0] p, input logic b, input logic ordy,
                          input logic ev, input logic [15:0] ei, input logic [31:0] ep,
                          input logic eb, input logic [1:0] eo, input logic er);
        vector_t v;
        v.rst = r; v.flush = f; v.inValid = iv; v.instr = ins; v.pc = p; v.bubble = b;
        v.outReady = ordy; v.expValid = ev; v.expInstr = ei; v.expPc = ep;
        v.expBubble = eb; v.expOcc = eo; v.expInReady = er;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vector_t v);
        rst1      = v.rst;
        flush1    = v.flush;
        inValid1  = v.inValid;
        inInstr1  = v.instr;
        inPc1     = v.pc;
        inNextPc1 = v.pc + 32'h2;
        inBubble1 = v.bubble;
        outReady1 = v.outReady;
    endtask

    task automatic driveNoSkid(input logic r, input logic iv, input logic [15:0] ins,
                               input logic [31:0] p, input logic b, input logic ordy);
        rst0      = r;
        flush0    = 1'b0;
        inValid0  = iv;
        inInstr0  = ins;
        inPc0     = p;
        inNextPc0 = p + 32'h2;
        inBubble0 = b;
        outReady0 = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //     rst flush iv  instr     pc        b  ordy | ev  instr     pc        eb occ   rdy
        // Reset with in_valid high
        addVec(1, 0, 1, 16'h1234, 32'h050, 0, 0,  0, 16'h0000, 32'h000, 0, 2'd0, 1);
        addVec(0, 0, 0, 16'h0000, 32'h000, 0, 0,  0, 16'h0000, 32'h000, 0, 2'd0, 1);
        // Streaming
        addVec(0, 0, 1, 16'h1111, 32'h100, 0, 1,  1, 16'h1111, 32'h100, 0, 2'd1, 1);
        addVec(0, 0, 1, 16'h2222, 32'h104, 0, 1,  1, 16'h2222, 32'h104, 0, 2'd1, 1);
        addVec(0, 0, 1, 16'h3333, 32'h108, 0, 1,  1, 16'h3333, 32'h108, 0, 2'd1, 1);
        addVec(0, 0, 1, 16'h4444, 32'h10C, 0, 1,  1, 16'h4444, 32'h10C, 0, 2'd1, 1);
        addVec(0, 0, 0, 16'h0000, 32'h000, 0, 1,  0, 16'h0000, 32'h000, 0, 2'd0, 1);
        // Stall into the skid, refused offer while full, then drain
        addVec(0, 0, 1, 16'hAAAA, 32'h200, 0, 0,  1, 16'hAAAA, 32'h200, 0, 2'd1, 1);
        addVec(0, 0, 1, 16'hBBBB, 32'h204, 0, 0,  1, 16'hAAAA, 32'h200, 0, 2'd2, 0);
        addVec(0, 0, 1, 16'h9999, 32'h208, 0, 0,  1, 16'hAAAA, 32'h200, 0, 2'd2, 0);
        addVec(0, 0, 0, 16'h0000, 32'h000, 0, 1,  1, 16'hBBBB, 32'h204, 0, 2'd1, 1);
        addVec(0, 0, 0, 16'h0000, 32'h000, 0, 1,  0, 16'h0000, 32'h000, 0, 2'd0, 1);
        // Flush while full with a word offered
        addVec(0, 0, 1, 16'hA1A1, 32'h300, 0, 0,  1, 16'hA1A1, 32'h300, 0, 2'd1, 1);
        addVec(0, 0, 1, 16'hB1B1, 32'h304, 1, 0,  1, 16'hA1A1, 32'h300, 0, 2'd2, 0);
        addVec(0, 1, 1, 16'hCCCC, 32'h308, 0, 1,  0, 16'h0000, 32'h000, 0, 2'd0, 1);
        addVec(0, 0, 0, 16'h0000, 32'h000, 0, 1,  0, 16'h0000, 32'h000, 0, 2'd0, 1);
        // Bubble tag follows its word only
        addVec(0, 0, 1, 16'hD0D0, 32'h400, 1, 0,  1, 16'hD0D0, 32'h400, 1, 2'd1, 1);
        addVec(0, 0, 1, 16'hE0E0, 32'h404, 0, 1,  1, 16'hE0E0, 32'h404, 0, 2'd1, 1);
        // Reset beats accept and pop; reset together with flush
        addVec(1, 0, 1, 16'hF0F0, 32'h408, 1, 1,  0, 16'h0000, 32'h000, 0, 2'd0, 1);
        addVec(0, 0, 1, 16'h1212, 32'h500, 0, 0,  1, 16'h1212, 32'h500, 0, 2'd1, 1);
        addVec(1, 1, 1, 16'h1313, 32'h504, 1, 1,  0, 16'h0000, 32'h000, 0, 2'd0, 1);
        // Flush beats accept and pop
        addVec(0, 0, 1, 16'h3434, 32'h600, 1, 0,  1, 16'h3434, 32'h600, 1, 2'd1, 1);
        addVec(0, 1, 1, 16'h5656, 32'h604, 1, 1,  0, 16'h0000, 32'h000, 0, 2'd0, 1);
        addVec(0, 0, 1, 16'h7878, 32'h608, 0, 0,  1, 16'h7878, 32'h608, 0, 2'd1, 1);

        driveNoSkid(1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d outValid", i), {31'b0, outValid1}, {31'b0, vecs[i].expValid});
            checkOutput($sformatf("vec%0d outInstr", i), {16'b0, outInstr1}, {16'b0, vecs[i].expInstr});
            checkOutput($sformatf("vec%0d outPc", i), outPc1, vecs[i].expPc);
            checkOutput($sformatf("vec%0d outNextPc", i), outNextPc1,
                        vecs[i].expValid ? vecs[i].expPc + 32'h2 : 32'h0);
            checkOutput($sformatf("vec%0d outBubble", i), {31'b0, outBubble1}, {31'b0, vecs[i].expBubble});
            checkOutput($sformatf("vec%0d occupancy", i), {30'b0, occ1}, {30'b0, vecs[i].expOcc});
            checkOutput($sformatf("vec%0d inReady", i), {31'b0, inReady1}, {31'b0, vecs[i].expInReady});
        end

        // Single-entry variant: combinational ready, replace-on-pop, bubble tag.
        driveNoSkid(1'b1, 1'b0, 16'h0, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("noskid reset occ", {30'b0, occ0}, 32'd0);
        checkOutput("noskid reset inReady", {31'b0, inReady0}, 32'd1);

        driveNoSkid(1'b0, 1'b1, 16'hDDDD, 32'h700, 1'b0, 1'b0);
        tick();
        checkOutput("noskid D head", {16'b0, outInstr0}, 32'h0000DDDD);
        checkOutput("noskid D occ", {30'b0, occ0}, 32'd1);

        driveNoSkid(1'b0, 1'b1, 16'hEEEE, 32'h704, 1'b0, 1'b0);
        #1;
        checkOutput("noskid stall inReady", {31'b0, inReady0}, 32'd0);
        tick();
        checkOutput("noskid D held", {16'b0, outInstr0}, 32'h0000DDDD);
        checkOutput("noskid held occ", {30'b0, occ0}, 32'd1);

        outReady0 = 1'b1;
        #1;
        checkOutput("noskid release inReady", {31'b0, inReady0}, 32'd1);
        tick();
        checkOutput("noskid E head", {16'b0, outInstr0}, 32'h0000EEEE);
        checkOutput("noskid E pc", outPc0, 32'h704);
        checkOutput("noskid E occ", {30'b0, occ0}, 32'd1);

        driveNoSkid(1'b0, 1'b1, 16'hF00F, 32'h708, 1'b1, 1'b1);
        tick();
        checkOutput("noskid bubble head", {31'b0, outBubble0}, 32'd1);
        checkOutput("noskid bubble nextPc", outNextPc0, 32'h70A);

        driveNoSkid(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 1'b1);
        tick();
        checkOutput("noskid drained valid", {31'b0, outValid0}, 32'd0);
        checkOutput("noskid drained bubble", {31'b0, outBubble0}, 32'd0);
        checkOutput("noskid drained occ", {30'b0, occ0}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
